// File: rtl/lift_dispatcher.sv
// lift_dispatcher: two-car group dispatcher latching hall calls and assigning each to the cheaper car
module lift_dispatcher #(
    parameter int FLOORS   = 7,
    parameter int FW       = 3,
    parameter int BUSY_PEN = 3
) (
    input  logic              clk,
    input  logic              start,
    input  logic [FLOORS-1:0] hall_up,
    input  logic [FLOORS-1:0] hall_down,
    input  logic [FW-1:0]     car0_floor,
    input  logic [FW-1:0]     car1_floor,
    input  logic              car0_busy,
    input  logic              car1_busy,
    input  logic              car0_en,
    input  logic              car1_en,
    input  logic [FLOORS-1:0] car0_srv_up,
    input  logic [FLOORS-1:0] car0_srv_down,
    input  logic [FLOORS-1:0] car1_srv_up,
    input  logic [FLOORS-1:0] car1_srv_down,
    output logic [FLOORS-1:0] hall_up_lamp,
    output logic [FLOORS-1:0] hall_down_lamp,
    output logic [FLOORS-1:0] car0_up_req,
    output logic [FLOORS-1:0] car0_down_req,
    output logic [FLOORS-1:0] car1_up_req,
    output logic [FLOORS-1:0] car1_down_req
);
    localparam int NS = 2 * FLOORS;
    localparam int SW = $clog2(NS);
    typedef enum logic [1:0] {IDLE, SCAN, COST, GRANT} state_t;
    state_t          state, state_n;
    logic [NS-1:0]   pend, pend_n, asg_v, asg_v_n, asg_c, asg_c_n;
    logic [NS-1:0]   valid, press, srv, cand, own_off, set;
    logic [SW-1:0]   ptr, ptr_n, slot, slot_n, hit;
    logic [FW-1:0]   slot_floor, slot_floor_n;
    logic [4:0]      cost0, cost1, cost0_n, cost1_n;
    logic            rr, rr_n, found, ok, pick1, tie;
    function automatic logic [4:0] cost_of(input logic [FW-1:0] f, input logic [FW-1:0] c,
                                           input logic busy, input logic en);
        logic [FW-1:0] d;
        d = (f >= c) ? f - c : c - f;
        return en ? 5'(d) + (busy ? 5'(BUSY_PEN) : 5'd0) : 5'd31;
    endfunction
    // top floor has no up call, ground floor has no down call
    assign valid   = {{(FLOORS-1){1'b1}}, 1'b0, 1'b0, {(FLOORS-1){1'b1}}};
    assign press   = {hall_down, hall_up} & valid;
    assign srv     = {car0_srv_down | car1_srv_down, car0_srv_up | car1_srv_up} & valid;
    assign cand    = pend & ~asg_v;
    assign ok      = cand[slot] & (car0_en | car1_en);
    assign tie     = cost0 == cost1;
    assign pick1   = (cost1 < cost0) | (tie & rr);
    always_comb begin
        found = 1'b0;
        hit   = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (cand[(int'(ptr) + k) % NS]) begin
                found = 1'b1;
                hit   = SW'((int'(ptr) + k) % NS);
            end
        end
    end
    always_comb begin
        state_n      = state;
        slot_n       = slot;
        slot_floor_n = slot_floor;
        cost0_n      = cost0;
        cost1_n      = cost1;
        ptr_n        = ptr;
        rr_n         = rr;
        asg_c_n      = asg_c;
        set          = '0;
        case (state)
            IDLE: state_n = (|cand && (car0_en || car1_en)) ? SCAN : IDLE;
            SCAN: begin
                state_n      = found ? COST : IDLE;
                slot_n       = hit;
                slot_floor_n = (hit < SW'(FLOORS)) ? FW'(hit) : FW'(hit - SW'(FLOORS));
            end
            COST: begin
                cost0_n = cost_of(slot_floor, car0_floor, car0_busy, car0_en);
                cost1_n = cost_of(slot_floor, car1_floor, car1_busy, car1_en);
                state_n = GRANT;
            end
            default: begin
                state_n = IDLE;
                if (ok) begin
                    set[slot]     = 1'b1;
                    asg_c_n[slot] = pick1;
                    rr_n          = tie ? ~rr : rr;
                    ptr_n         = (slot == SW'(NS - 1)) ? '0 : slot + 1'b1;
                end
            end
        endcase
    end
    // ownership by a car that is out of service is dropped so the call gets reassigned
    assign own_off = (asg_c_n & {NS{~car1_en}}) | (~asg_c_n & {NS{~car0_en}});
    assign pend_n  = (pend | press) & ~srv;
    assign asg_v_n = (asg_v | set) & ~srv & ~own_off;
    always_ff @(posedge clk) begin
        if (start) begin
            state          <= IDLE;
            pend           <= '0;
            asg_v          <= '0;
            asg_c          <= '0;
            ptr            <= '0;
            rr             <= 1'b0;
            slot           <= '0;
            slot_floor     <= '0;
            cost0          <= '0;
            cost1          <= '0;
            hall_up_lamp   <= '0;
            hall_down_lamp <= '0;
            car0_up_req    <= '0;
            car0_down_req  <= '0;
            car1_up_req    <= '0;
            car1_down_req  <= '0;
        end else begin
            state          <= state_n;
            pend           <= pend_n;
            asg_v          <= asg_v_n;
            asg_c          <= asg_c_n;
            ptr            <= ptr_n;
            rr             <= rr_n;
            slot           <= slot_n;
            slot_floor     <= slot_floor_n;
            cost0          <= cost0_n;
            cost1          <= cost1_n;
            hall_up_lamp   <= pend_n[FLOORS-1:0];
            hall_down_lamp <= pend_n[NS-1:FLOORS];
            car0_up_req    <= pend_n[FLOORS-1:0] & asg_v_n[FLOORS-1:0] & ~asg_c_n[FLOORS-1:0];
            car0_down_req  <= pend_n[NS-1:FLOORS] & asg_v_n[NS-1:FLOORS] & ~asg_c_n[NS-1:FLOORS];
            car1_up_req    <= pend_n[FLOORS-1:0] & asg_v_n[FLOORS-1:0] & asg_c_n[FLOORS-1:0];
            car1_down_req  <= pend_n[NS-1:FLOORS] & asg_v_n[NS-1:FLOORS] & asg_c_n[NS-1:FLOORS];
        end
    end
endmodule

// File: tb/tb_lift_dispatcher.sv
// tb_lift_dispatcher: directed scenario bench for the two-car hall call dispatcher
module tb_lift_dispatcher;
    logic       clk = 1'b0;
    logic       start;
    logic [6:0] hall_up, hall_down;
    logic [2:0] car0_floor, car1_floor;
    logic       car0_busy, car1_busy, car0_en, car1_en;
    logic [6:0] car0_srv_up, car0_srv_down, car1_srv_up, car1_srv_down;
    logic [6:0] hall_up_lamp, hall_down_lamp;
    logic [6:0] car0_up_req, car0_down_req, car1_up_req, car1_down_req;
    int         errors = 0;
    int         checks = 0;
    lift_dispatcher dut (
        .clk(clk), .start(start), .hall_up(hall_up), .hall_down(hall_down),
        .car0_floor(car0_floor), .car1_floor(car1_floor),
        .car0_busy(car0_busy), .car1_busy(car1_busy),
        .car0_en(car0_en), .car1_en(car1_en),
        .car0_srv_up(car0_srv_up), .car0_srv_down(car0_srv_down),
        .car1_srv_up(car1_srv_up), .car1_srv_down(car1_srv_down),
        .hall_up_lamp(hall_up_lamp), .hall_down_lamp(hall_down_lamp),
        .car0_up_req(car0_up_req), .car0_down_req(car0_down_req),
        .car1_up_req(car1_up_req), .car1_down_req(car1_down_req)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset(input logic [2:0] f0, input logic [2:0] f1);
        hall_up = '0; hall_down = '0;
        car0_srv_up = '0; car0_srv_down = '0; car1_srv_up = '0; car1_srv_down = '0;
        car0_busy = 1'b0; car1_busy = 1'b0; car0_en = 1'b1; car1_en = 1'b1;
        car0_floor = f0; car1_floor = f1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic test_reset();
        do_reset(3'd0, 3'd5);
        start = 1'b1;
        hall_up = 7'b0000100;
        hall_down = 7'b0010000;
        tick();
        hall_up = '0; hall_down = '0;
        start = 1'b0;
        checks++;
        if (hall_up_lamp !== 7'b0 || hall_down_lamp !== 7'b0) begin
            errors++;
            $display("FAIL reset_lamps: up=%b down=%b expected 0000000", hall_up_lamp, hall_down_lamp);
        end
        checks++;
        if ({car0_up_req, car0_down_req, car1_up_req, car1_down_req} !== 28'b0) begin
            errors++;
            $display("FAIL reset_reqs: %b %b %b %b expected all 0", car0_up_req, car0_down_req, car1_up_req, car1_down_req);
        end
        tick(5);
        checks++;
        if (hall_up_lamp !== 7'b0 || car0_up_req !== 7'b0) begin
            errors++;
            $display("FAIL reset_override: lamp=%b req0=%b expected 0000000", hall_up_lamp, car0_up_req);
        end
    endtask
    task automatic test_assign();
        do_reset(3'd0, 3'd5);
        hall_up = 7'b0000100;
        tick();
        hall_up = '0;
        checks++;
        if (hall_up_lamp !== 7'b0000100) begin
            errors++;
            $display("FAIL assign_lamp: got %b expected 0000100", hall_up_lamp);
        end
        tick(3);
        checks++;
        if (car0_up_req !== 7'b0) begin
            errors++;
            $display("FAIL assign_early: car0_up_req=%b expected 0000000 after E3", car0_up_req);
        end
        tick();
        checks++;
        if (car0_up_req !== 7'b0000100) begin
            errors++;
            $display("FAIL assign_e4: car0_up_req=%b expected 0000100", car0_up_req);
        end
        checks++;
        if (car1_up_req !== 7'b0 || car1_down_req !== 7'b0) begin
            errors++;
            $display("FAIL assign_car1: up=%b down=%b expected 0000000", car1_up_req, car1_down_req);
        end
    endtask
    task automatic test_service();
        car1_srv_up = 7'b0000100;
        tick();
        car1_srv_up = '0;
        checks++;
        if (hall_up_lamp !== 7'b0 || car0_up_req !== 7'b0) begin
            errors++;
            $display("FAIL service_clear: lamp=%b req0=%b expected 0000000", hall_up_lamp, car0_up_req);
        end
        tick(5);
        checks++;
        if ({hall_up_lamp, car0_up_req, car1_up_req} !== 21'b0) begin
            errors++;
            $display("FAIL service_idle: lamp=%b req0=%b req1=%b expected 0", hall_up_lamp, car0_up_req, car1_up_req);
        end
    endtask
    task automatic test_tie();
        do_reset(3'd1, 3'd3);
        hall_down = 7'b0000100;
        tick();
        hall_down = '0;
        tick(4);
        checks++;
        if (car0_down_req !== 7'b0000100 || car1_down_req !== 7'b0) begin
            errors++;
            $display("FAIL tie_first: req0=%b req1=%b expected 0000100/0000000", car0_down_req, car1_down_req);
        end
        car0_srv_down = 7'b0000100;
        tick();
        car0_srv_down = '0;
        checks++;
        if (hall_down_lamp !== 7'b0 || car0_down_req !== 7'b0) begin
            errors++;
            $display("FAIL tie_serve: lamp=%b req0=%b expected 0000000", hall_down_lamp, car0_down_req);
        end
        hall_down = 7'b0000100;
        tick();
        hall_down = '0;
        tick(4);
        checks++;
        if (car1_down_req !== 7'b0000100 || car0_down_req !== 7'b0) begin
            errors++;
            $display("FAIL tie_second: req1=%b req0=%b expected 0000100/0000000", car1_down_req, car0_down_req);
        end
    endtask
    task automatic test_back_to_back();
        do_reset(3'd0, 3'd5);
        hall_up = 7'b0010010;
        tick();
        hall_up = '0;
        tick(4);
        checks++;
        if (car0_up_req !== 7'b0000010 || car1_up_req !== 7'b0) begin
            errors++;
            $display("FAIL b2b_first: req0=%b req1=%b expected 0000010/0000000", car0_up_req, car1_up_req);
        end
        tick(4);
        checks++;
        if (car0_up_req !== 7'b0000010 || car1_up_req !== 7'b0010000) begin
            errors++;
            $display("FAIL b2b_second: req0=%b req1=%b expected 0000010/0010000", car0_up_req, car1_up_req);
        end
    endtask
    task automatic test_disable();
        bit done;
        do_reset(3'd0, 3'd5);
        hall_up = 7'b0000100;
        tick();
        hall_up = '0;
        tick(4);
        checks++;
        if (car0_up_req !== 7'b0000100) begin
            errors++;
            $display("FAIL dis_owner: car0_up_req=%b expected 0000100", car0_up_req);
        end
        car0_en = 1'b0;
        tick();
        checks++;
        if (car0_up_req !== 7'b0 || hall_up_lamp !== 7'b0000100) begin
            errors++;
            $display("FAIL dis_drop: req0=%b lamp=%b expected 0000000/0000100", car0_up_req, hall_up_lamp);
        end
        done = 1'b0;
        for (int i = 0; i < 5 && !done; i++) begin
            tick();
            checks++;
            if (hall_up_lamp !== 7'b0000100) begin
                errors++;
                $display("FAIL dis_lamp: lamp=%b expected 0000100", hall_up_lamp);
            end
            done = car1_up_req[2];
        end
        checks++;
        if (car1_up_req !== 7'b0000100 || car0_up_req !== 7'b0) begin
            errors++;
            $display("FAIL dis_reassign: req1=%b req0=%b expected 0000100/0000000 within 5 cycles", car1_up_req, car0_up_req);
        end
        do_reset(3'd0, 3'd5);
        car0_en = 1'b0;
        car1_en = 1'b0;
        hall_down = 7'b0010000;
        tick();
        hall_down = '0;
        tick(6);
        checks++;
        if (hall_down_lamp !== 7'b0010000 || car0_down_req !== 7'b0 || car1_down_req !== 7'b0) begin
            errors++;
            $display("FAIL dis_both: lamp=%b req0=%b req1=%b expected 0010000/0/0", hall_down_lamp, car0_down_req, car1_down_req);
        end
        car0_en = 1'b1;
        tick(4);
        checks++;
        if (car0_down_req !== 7'b0010000) begin
            errors++;
            $display("FAIL dis_reenable: req0=%b expected 0010000", car0_down_req);
        end
    endtask
    task automatic test_busy_invalid();
        do_reset(3'd2, 3'd4);
        car0_busy = 1'b1;
        hall_up = 7'b0000100;
        tick();
        hall_up = '0;
        tick(4);
        checks++;
        if (car1_up_req !== 7'b0000100 || car0_up_req !== 7'b0) begin
            errors++;
            $display("FAIL busy_pen: req1=%b req0=%b expected 0000100/0000000", car1_up_req, car0_up_req);
        end
        hall_up = 7'b1000000;
        hall_down = 7'b0000001;
        tick();
        hall_up = '0; hall_down = '0;
        checks++;
        if (hall_up_lamp !== 7'b0000100 || hall_down_lamp !== 7'b0) begin
            errors++;
            $display("FAIL invalid_lamp: up=%b down=%b expected 0000100/0000000", hall_up_lamp, hall_down_lamp);
        end
        tick(5);
        checks++;
        if (car0_up_req !== 7'b0 || car1_up_req !== 7'b0000100 || car0_down_req !== 7'b0 || car1_down_req !== 7'b0) begin
            errors++;
            $display("FAIL invalid_req: %b %b %b %b expected 0/0000100/0/0", car0_up_req, car1_up_req, car0_down_req, car1_down_req);
        end
    endtask
    task automatic test_simul_reset();
        do_reset(3'd0, 3'd5);
        hall_down = 7'b0001000;
        car0_srv_down = 7'b0001000;
        tick();
        hall_down = '0; car0_srv_down = '0;
        checks++;
        if (hall_down_lamp !== 7'b0) begin
            errors++;
            $display("FAIL simul_lamp: lamp=%b expected 0000000", hall_down_lamp);
        end
        tick(4);
        checks++;
        if (car0_down_req !== 7'b0 || car1_down_req !== 7'b0) begin
            errors++;
            $display("FAIL simul_req: req0=%b req1=%b expected 0000000", car0_down_req, car1_down_req);
        end
        hall_up = 7'b0000010;
        tick();
        hall_up = '0;
        tick(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({hall_up_lamp, car0_up_req, car1_up_req} !== 21'b0) begin
            errors++;
            $display("FAIL grant_reset: lamp=%b req0=%b req1=%b expected 0", hall_up_lamp, car0_up_req, car1_up_req);
        end
        tick(5);
        checks++;
        if ({hall_up_lamp, car0_up_req, car1_up_req} !== 21'b0) begin
            errors++;
            $display("FAIL grant_discard: lamp=%b req0=%b req1=%b expected 0", hall_up_lamp, car0_up_req, car1_up_req);
        end
    endtask
    initial begin
        test_reset();
        test_assign();
        test_service();
        test_tie();
        test_back_to_back();
        test_disable();
        test_busy_invalid();
        test_simul_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lift_dispatcher.md
Name: lift_dispatcher

Overview:
- Group dispatcher for a two-car, seven-floor installation.
- Latches hall up/down calls and lights the hall lamps.
- Assigns each pending call to one car by a distance/busy cost, and drives per-car request vectors into each car's floor controller.
- Clears a call when a car reports service at that floor and direction.

Parameters:
FLOORS, 7, number of floors; floor index 0..FLOORS-1
FW, 3, width of binary floor index
BUSY_PEN, 3, cost penalty added when a car is busy

Ports:
clk  in  1  system clock, all logic on posedge
start  in  1  synchronous active-high reset
hall_up  in  FLOORS  hall up-call buttons, level or pulse
hall_down  in  FLOORS  hall down-call buttons
car0_floor  in  FW  car 0 current floor, binary
car1_floor  in  FW  car 1 current floor, binary
car0_busy  in  1  car 0 moving or door cycle active
car1_busy  in  1  car 1 moving or door cycle active
car0_en  in  1  car 0 in service
car1_en  in  1  car 1 in service
car0_srv_up  in  FLOORS  car 0 opened doors at floor i, going up (1-cycle pulse)
car0_srv_down  in  FLOORS  car 0 served down call at floor i
car1_srv_up  in  FLOORS  car 1 served up call at floor i
car1_srv_down  in  FLOORS  car 1 served down call at floor i
hall_up_lamp  out  FLOORS  pending up calls
hall_down_lamp  out  FLOORS  pending down calls
car0_up_req  out  FLOORS  up calls assigned to car 0
car0_down_req  out  FLOORS  down calls assigned to car 0
car1_up_req  out  FLOORS  up calls assigned to car 1
car1_down_req  out  FLOORS  down calls assigned to car 1

Behaviour:
- Slots: 0..FLOORS-1 are up calls at floor i; FLOORS..2*FLOORS-1 are down calls at floor i-FLOORS.
- Per-slot state: pend, asg_valid, asg_car. All outputs are registered.
- Invalid slots are hardwired 0 and never assigned: up at floor FLOORS-1, down at floor 0.
- Reset, start=1 at an edge:
  - pend, asg, scan pointer, round-robin bit (rr) all 0; FSM to IDLE; every output 0.
  - start overrides every other input in the same cycle.
- Press: a hall bit high at edge E0 sets pend at E0.
  - Lamp equals pend, so it is high after E0.
  - Pressing an already-pending slot has no effect.
- Service: any car's srv bit for a slot clears pend and asg_valid at that edge, whichever car owned the call.
  - If the same slot sees a press and a service in the same cycle, service wins and pend=0.
- Disable: a car with en=0 is never assigned.
  - All asg_valid entries owned by a disabled car clear on the next edge. Pend is kept, so those calls are reassigned.
  - With both cars disabled, calls stay pending and unassigned.
- FSM (IDLE, SCAN, COST, GRANT), one state per cycle:
  - IDLE: if any slot has pend & ~asg_valid and at least one car is enabled, go to SCAN; else stay.
  - SCAN: wrapped priority search from ptr for the first pend & ~asg slot. Latch slot index and floor, go to COST. If none is found (cleared meanwhile), go to IDLE.
  - COST: costN = |slot_floor - carN_floor| + (carN_busy ? BUSY_PEN : 0). Unsigned, 5 bits, no overflow. Disabled car cost = 31. Register both costs, go to GRANT.
  - GRANT:
    - If the slot is no longer pend & ~asg, or both cars are disabled, drop it and assign nothing.
    - Otherwise assign to the car with the lower cost. On a tie, assign to car rr, then toggle rr.
    - Set asg at this edge; ptr = slot+1, wrapping 2*FLOORS-1 to 0; go to IDLE.
- Latency: press at E0 gives lamp after E0 and carN_*_req after E4, with an idle FSM.
  - Each further call adds 4 cycles.
- Outputs:
  - carN_up_req[i] = pend & asg_valid & asg_car==N for up slot i; likewise for down.
  - A request drops on the edge where its call is serviced or its car is disabled.
- Car floor inputs ≥ FLOORS are a caller error. The cost is computed on the raw value and is not checked.
- Mid-operation start: FSM to IDLE, all state cleared; any in-flight grant is discarded.

Test Plan:
1. Reset; car0_floor=0, car1_floor=5, both idle and enabled; pulse hall_up[2] at E0 -> hall_up_lamp=7'b0000100 after E0; car0_up_req=7'b0000100 after E4; car1 requests all 0.
2. Tie: car0_floor=1, car1_floor=3, both idle; hall_down[2] -> car0_down_req[2]=1 (rr=0). Serve it, then hall_down[2] again -> car1_down_req[2]=1.
3. Service: with case 1 assigned, pulse car1_srv_up[2] (non-owner) -> next edge lamp[2]=0 and car0_up_req[2]=0; FSM stays IDLE.
4. Disable and reassign: car0 owns up[2]; drop car0_en -> car0_up_req[2]=0 next edge; car1_up_req[2]=1 within 5 cycles; lamp stays 1 throughout.
5. Busy penalty and invalid slots:
   - car0_floor=2 busy, car1_floor=4 idle; hall_up[2] -> costs 3 vs 2, car1 assigned.
   - hall_up[6] and hall_down[0] -> lamps stay 0, no requests.
6. Simultaneous/reset: press and car0_srv_down[3] on the same edge -> lamp stays 0. Assert start while FSM is in GRANT -> all outputs 0 next edge, no assignment.
